complex_nx1_arb_mux: RTL and testbench
======================================

# complex_nx1_arb_mux

Parametrised N-channel successor of the complex 2:1 mux. It selects one of N_CH complex samples (packed real/imag) onto a single registered output with valid/ready handshakes. Channel choice is either an explicit select or fair round-robin arbitration among the valid channels. It sits between parallel complex datapaths (multipliers, adders) and a shared downstream consumer such as an accumulator or output FIFO.

## Interface
Parameters:
- HALF_W, 32: width of each real/imag component; one complex word is 2*HALF_W bits.
- N_CH, 4: number of input channels; legal range 2..16.
- SEL_W, $clog2(N_CH): select/channel-index width (derived, not overridden).

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_data  in  N_CH*2*HALF_W  channel i occupies [i*2*HALF_W +: 2*HALF_W]; real part in upper HALF_W bits, imag part in lower HALF_W bits.
- in_valid  in  N_CH  per-channel valid.
- in_ready  out  N_CH  per-channel ready; at most one bit high per cycle.
- mode  in  1  0 = fixed select via mux_sel; 1 = round-robin.
- mux_sel  in  SEL_W  channel index used in fixed mode.
- out_data  out  2*HALF_W  registered selected complex word.
- out_valid  out  1  output register holds a word.
- out_ready  in  1  downstream accept.
- out_ch  out  SEL_W  index of the channel that supplied out_data.

## Operation
- Output register state: EMPTY (out_valid=0) or FULL (out_valid=1).
- slot_free = !out_valid | out_ready.
- Grant, fixed mode: grant = mux_sel if mux_sel < N_CH and in_valid[mux_sel]; else no grant.
- Grant, RR mode: the first valid channel searching from rr_ptr+1 upward, wrapping modulo N_CH; no grant if no channel is valid.
- in_ready[g] = slot_free for granted channel g; all other bits are 0. in_ready is combinational from in_valid, mode, mux_sel and out_ready.
- Transfer on channel g when in_valid[g] & in_ready[g].
- On transfer: out_data <= word g unmodified; out_ch <= g; out_valid <= 1.
- Without transfer: if out_ready & out_valid, then out_valid <= 0; otherwise hold.
- out_data and out_ch hold stable while out_valid=1 and out_ready=0.
- rr_ptr <= g only on a transfer that occurs in RR mode. It is not updated in fixed mode or on stalls.
- mode and mux_sel are sampled every cycle and only affect new grants; a held output word is never altered.
- Out-of-range mux_sel (N_CH not a power of 2): no grant and no transfer; this is not an error.
- Data passes through bit-exact; the block performs no arithmetic on the samples.

## Timing
- Reset values: out_valid=0, out_data=0, out_ch=0, rr_ptr=N_CH-1 (so the first RR search starts at channel 0). in_ready is 0 while rst is high.
- Latency is 1 cycle from input transfer to out_valid.
- Throughput is 1 word/cycle with out_ready held high, including a drain and refill in the same cycle.
- Simultaneous drain and accept: out_valid stays 1 and the new word replaces the old one.
- Reset asserted mid-transfer: the word is discarded, outputs take their reset values immediately (asynchronous), and the first grant after release is RR channel 0.
- Single valid channel in RR mode: it is granted every cycle; there is no dead cycle between grants.

## Structure
- Shared package complex_pkg: constant CPLX_W = 2*HALF_W; functions cplx_re()/cplx_im() for field extraction. Benches reuse the package.
- Sub-module complex_rr_arbiter (parameter N_CH): takes req[N_CH] and the pointer, and returns a one-hot grant plus its index. It is purely combinational; rr_ptr lives in the parent.
- The top level holds the grant mux, the handshake logic and the output register. Target size is about 150-250 lines.

## Test plan
- Fixed mode, N_CH=4, mux_sel=2, in_valid=4'b0100, channel 2 = {re 0x00000005, im 0xFFFFFFFB}, out_ready=1 -> next cycle out_data=0x00000005_FFFFFFFB, out_ch=2, out_valid=1; in_ready=4'b0100 during the transfer.
- RR mode, all channels valid continuously, out_ready=1 -> out_ch sequence 0,1,2,3,0,1 on consecutive cycles, with no bubbles.
- Backpressure: out_ready=0 for 3 cycles while out_valid=1 -> out_data and out_ch are unchanged, in_ready=0, rr_ptr is unchanged; after out_ready rises, the next channel in RR order is granted.
- RR with in_valid=4'b1010 -> grants alternate 1,3,1,3; then set in_valid=4'b0001 -> channel 0 is granted every cycle.
- Fixed mode, N_CH=3, mux_sel=3 -> in_ready=0 and out_valid falls after the drain; async rst pulse mid-stream -> out_valid=0 at once, and the first RR grant after release is channel 0.

Source files
------------

// File: rtl/complex_pkg.sv
// ----------------------------------------------------------------------------
// complex_pkg
//   Shared definitions for the complex-sample datapath blocks.
//   A complex word is packed as {real, imag}, with the real part in the upper
//   half and the imag part in the lower half. The field widths here are the
//   default datapath widths; blocks that are parameterised on HALF_W carry
//   their own width and use these helpers only when they match.
//
//   Contents:
//     CPLX_HALF_W / CPLX_W : default component and word widths
//     half_t / cplx_t      : matching vector types
//     mode_e               : arbitration mode encoding for the N:1 mux
//     cplx_re / cplx_im    : field extraction
//     cplx_pack            : field packing
// ----------------------------------------------------------------------------
package complex_pkg;

    localparam int CPLX_HALF_W = 32;
    localparam int CPLX_W      = 2 * CPLX_HALF_W;

    typedef logic [CPLX_HALF_W-1:0] half_t;
    typedef logic [CPLX_W-1:0]      cplx_t;

    typedef enum logic {
        MODE_FIXED = 1'b0,
        MODE_RR    = 1'b1
    } mode_e;

    function automatic half_t cplx_re(input cplx_t w);
        return w[CPLX_W-1:CPLX_HALF_W];
    endfunction

    function automatic half_t cplx_im(input cplx_t w);
        return w[CPLX_HALF_W-1:0];
    endfunction

    function automatic cplx_t cplx_pack(input half_t re, input half_t im);
        return {re, im};
    endfunction

endpackage

// File: rtl/complex_rr_arbiter.sv
// ----------------------------------------------------------------------------
// complex_rr_arbiter
//   Purely combinational round-robin arbiter. Starting one position after
//   ptr and wrapping modulo N_CH, the first asserted request wins. The
//   pointer register lives in the parent so that it can decide when the
//   pointer is allowed to advance.
//
//   Ports:
//     req       in  N_CH   request vector
//     ptr       in  SEL_W  index of the last channel served
//     grant     out N_CH   one-hot grant (all zero when nothing requests)
//     grant_idx out SEL_W  index of the granted channel (0 when none)
//     grant_vld out 1      a grant was issued
// ----------------------------------------------------------------------------
module complex_rr_arbiter #(
    parameter  int N_CH  = 4,
    localparam int SEL_W = $clog2(N_CH)
) (
    input  logic [N_CH-1:0]  req,
    input  logic [SEL_W-1:0] ptr,
    output logic [N_CH-1:0]  grant,
    output logic [SEL_W-1:0] grant_idx,
    output logic             grant_vld
);

    always_comb begin
        int idx;
        grant     = '0;
        grant_idx = '0;
        grant_vld = 1'b0;
        idx       = 0;
        // Offsets 1..N_CH visit every channel once, ending on ptr itself,
        // so the most recently served channel has the lowest priority.
        for (int i = 1; i <= N_CH; i++) begin
            idx = (int'(ptr) + i) % N_CH;
            if (!grant_vld && req[idx]) begin
                grant_vld  = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = SEL_W'(idx);
            end
        end
    end

endmodule

// File: rtl/complex_nx1_arb_mux.sv
// ----------------------------------------------------------------------------
// complex_nx1_arb_mux
//   N_CH:1 multiplexer for packed complex samples with valid/ready on every
//   side and a single registered output slot. The source channel is either
//   chosen explicitly (fixed mode) or by fair round-robin among the valid
//   channels. Samples pass through bit-exact.
//
//   Parameters:
//     HALF_W  width of each real/imag component (word = 2*HALF_W)
//     N_CH    number of input channels (2..16)
//     SEL_W   channel index width, derived
//
//   Ports:
//     clk, rst   clock and asynchronous active-high reset
//     in_data    N_CH packed words, channel i at [i*2*HALF_W +: 2*HALF_W]
//     in_valid   per-channel valid
//     in_ready   per-channel ready, at most one bit set
//     mode       0 = fixed select via mux_sel, 1 = round-robin
//     mux_sel    channel index used in fixed mode
//     out_data   registered selected word
//     out_valid  output slot holds a word
//     out_ready  downstream accept
//     out_ch     channel that supplied out_data
// ----------------------------------------------------------------------------
module complex_nx1_arb_mux
    import complex_pkg::*;
#(
    parameter  int HALF_W = 32,
    parameter  int N_CH   = 4,
    localparam int SEL_W  = $clog2(N_CH),
    localparam int WORD_W = 2 * HALF_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_CH*WORD_W-1:0] in_data,
    input  logic [N_CH-1:0]        in_valid,
    output logic [N_CH-1:0]        in_ready,
    input  logic                   mode,
    input  logic [SEL_W-1:0]       mux_sel,
    output logic [WORD_W-1:0]      out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [SEL_W-1:0]       out_ch
);

    // Valid vector padded to the full select range so that an out-of-range
    // mux_sel (N_CH not a power of two) reads a zero instead of indexing
    // past the end of in_valid.
    localparam int                N_PAD   = 1 << SEL_W;
    localparam logic [SEL_W-1:0]  PTR_RST = SEL_W'(N_CH - 1);

    logic [N_PAD-1:0]  valid_pad;
    logic              slot_free;
    logic              fix_vld;
    logic              rr_vld;
    logic [N_CH-1:0]   rr_onehot;
    logic [SEL_W-1:0]  rr_idx;
    logic              gnt_vld;
    logic [N_CH-1:0]   gnt_onehot;
    logic [SEL_W-1:0]  gnt_idx;
    logic [WORD_W-1:0] gnt_word;
    logic              xfer;

    logic              out_valid_q, out_valid_d;
    logic [WORD_W-1:0] out_data_q,  out_data_d;
    logic [SEL_W-1:0]  out_ch_q,    out_ch_d;
    logic [SEL_W-1:0]  rr_ptr_q,    rr_ptr_d;

    complex_rr_arbiter #(
        .N_CH (N_CH)
    ) u_rr_arb (
        .req       (in_valid),
        .ptr       (rr_ptr_q),
        .grant     (rr_onehot),
        .grant_idx (rr_idx),
        .grant_vld (rr_vld)
    );

    // Grant selection and handshake
    always_comb begin
        valid_pad  = N_PAD'(in_valid);
        fix_vld    = (int'(mux_sel) < N_CH) && valid_pad[mux_sel];
        slot_free  = !out_valid_q || out_ready;

        gnt_vld    = 1'b0;
        gnt_idx    = '0;
        gnt_onehot = '0;
        if (mode == MODE_RR) begin
            gnt_vld    = rr_vld;
            gnt_idx    = rr_idx;
            gnt_onehot = rr_onehot;
        end else if (fix_vld) begin
            gnt_vld = 1'b1;
            gnt_idx = mux_sel;
            for (int i = 0; i < N_CH; i++) begin
                gnt_onehot[i] = (int'(mux_sel) == i);
            end
        end

        // Only the granted channel can see ready, and only when the output
        // slot is empty or being drained this cycle.
        in_ready = gnt_onehot & {N_CH{slot_free && !rst}};
        xfer     = gnt_vld && slot_free && !rst;

        gnt_word = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (gnt_onehot[i]) begin
                gnt_word = in_data[i*WORD_W +: WORD_W];
            end
        end
    end

    // Output slot and pointer next state
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        rr_ptr_d    = rr_ptr_q;

        if (xfer) begin
            // Covers the drain-and-refill case: the new word simply replaces
            // the one being accepted downstream.
            out_valid_d = 1'b1;
            out_data_d  = gnt_word;
            out_ch_d    = gnt_idx;
            if (mode == MODE_RR) begin
                rr_ptr_d = gnt_idx;
            end
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Registered output slot
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            rr_ptr_q    <= PTR_RST;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_complex_nx1_arb_mux.sv
// ----------------------------------------------------------------------------
// tb_complex_nx1_arb_mux
//   Bench for complex_nx1_arb_mux. A driver applies one input pattern per
//   cycle and, from a behavioural model of the grant rules, predicts
//   in_ready, out_valid and the word that will be captured; predicted words
//   go into a queue. A separate monitor pops that queue whenever the DUT
//   presents a word that downstream accepts. A second small instance with
//   N_CH=3 covers the out-of-range select case.
// ----------------------------------------------------------------------------
module tb_complex_nx1_arb_mux;
    import complex_pkg::*;

    localparam int N  = 4;
    localparam int HW = 32;
    localparam int W  = 2 * HW;
    localparam int SW = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic [N*W-1:0]   in_data;
    logic [N-1:0]     in_valid;
    logic [N-1:0]     in_ready;
    logic             mode;
    logic [SW-1:0]    mux_sel;
    logic [W-1:0]     out_data;
    logic             out_valid;
    logic             out_ready;
    logic [SW-1:0]    out_ch;

    logic [3*W-1:0]   in_data3;
    logic [2:0]       in_valid3;
    logic [2:0]       in_ready3;
    logic             mode3;
    logic [1:0]       sel3;
    logic [W-1:0]     out_data3;
    logic             out_valid3;
    logic             out_ready3;
    logic [1:0]       out_ch3;

    complex_nx1_arb_mux #(.HALF_W(HW), .N_CH(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .mux_sel   (mux_sel),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ch    (out_ch)
    );

    complex_nx1_arb_mux #(.HALF_W(HW), .N_CH(3)) dut3 (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data3),
        .in_valid  (in_valid3),
        .in_ready  (in_ready3),
        .mode      (mode3),
        .mux_sel   (sel3),
        .out_data  (out_data3),
        .out_valid (out_valid3),
        .out_ready (out_ready3),
        .out_ch    (out_ch3)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] d;
        int           ch;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    // Model state: whether the output slot holds a word, and the last
    // channel served in round-robin mode.
    int occ  = 0;
    int last = N - 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int exp_grant(input logic [N-1:0] v, input logic m, input int s, input int lst);
        int c;
        if (!m) begin
            if (s < N && v[s]) return s;
            return -1;
        end
        for (int j = 1; j <= N; j++) begin
            c = (lst + j) % N;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    function automatic logic [N*W-1:0] rand_data();
        logic [N*W-1:0] d;
        for (int i = 0; i < N; i++) d[i*W +: W] = {$urandom, $urandom};
        return d;
    endfunction

    // Called one time unit after a rising edge; returns at the same point
    // of the following cycle.
    task automatic step(input logic [N-1:0] v, input logic m, input logic [SW-1:0] s,
                        input logic ordy, input logic [N*W-1:0] d);
        int         g;
        logic       sf;
        logic [N-1:0] er;
        in_data   = d;
        in_valid  = v;
        mode      = m;
        mux_sel   = s;
        out_ready = ordy;
        #1;
        check("out_valid", {63'd0, out_valid}, occ);
        g  = exp_grant(v, m, int'(s), last);
        sf = (occ == 0) || ordy;
        er = '0;
        if (g >= 0 && sf) er[g] = 1'b1;
        check("in_ready", {60'd0, in_ready}, {60'd0, er});
        if (g >= 0 && sf) begin
            sb.push_back('{d[g*W +: W], g});
            occ = 1;
            if (m) last = g;
        end else if (ordy) begin
            occ = 0;
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: a word leaves when out_valid and out_ready are both high.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_word", {62'd0, out_ch}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("out_data", out_data, e.d);
                check("out_ch", {62'd0, out_ch}, e.ch);
            end
        end
    end

    initial begin
        logic [N*W-1:0] d;

        rst        = 1'b1;
        in_data    = '0;
        in_valid   = '1;
        mode       = 1'b1;
        mux_sel    = '0;
        out_ready  = 1'b1;
        in_data3   = '0;
        in_valid3  = '0;
        mode3      = 1'b0;
        sel3       = '0;
        out_ready3 = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", {63'd0, out_valid}, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_ch", {62'd0, out_ch}, 0);
        check("rst_in_ready", {60'd0, in_ready}, 0);
        rst = 1'b0;

        // Fixed select of channel 2 with a known sample
        d = rand_data();
        d[2*W +: W] = cplx_pack(32'h0000_0005, 32'hFFFF_FFFB);
        check("pkg_re", {32'd0, cplx_re(d[2*W +: W])}, 64'h5);
        step(4'b0100, 1'b0, 2'd2, 1'b1, d);
        step(4'b0000, 1'b0, 2'd2, 1'b1, rand_data());

        // Round-robin with every channel valid
        repeat (6) step(4'b1111, 1'b1, 2'd0, 1'b1, rand_data());

        // Backpressure while full, then release
        repeat (3) step(4'b1111, 1'b1, 2'd0, 1'b0, rand_data());
        repeat (3) step(4'b1111, 1'b1, 2'd0, 1'b1, rand_data());

        // Sparse requests, then a single requester
        repeat (4) step(4'b1010, 1'b1, 2'd0, 1'b1, rand_data());
        repeat (3) step(4'b0001, 1'b1, 2'd0, 1'b1, rand_data());

        // Randomised traffic
        repeat (400) begin
            step(4'($urandom), 1'($urandom), 2'($urandom), ($urandom_range(0, 3) != 0), rand_data());
        end

        // Asynchronous reset in the middle of a stream
        repeat (2) step(4'b1111, 1'b1, 2'd0, 1'b1, rand_data());
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_out_valid", {63'd0, out_valid}, 0);
        check("async_rst_in_ready", {60'd0, in_ready}, 0);
        sb.delete();
        occ  = 0;
        last = N - 1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (5) step(4'b1111, 1'b1, 2'd0, 1'b1, rand_data());

        // Drain: all predicted words must have been seen
        repeat (3) step(4'b0000, 1'b1, 2'd0, 1'b1, rand_data());
        check("sb_drained", sb.size(), 0);

        // Three-channel instance: legal select, then out-of-range select
        in_data3 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        in_valid3  = 3'b111;
        mode3      = 1'b0;
        sel3       = 2'd1;
        out_ready3 = 1'b1;
        #1;
        check("n3_in_ready_sel1", {61'd0, in_ready3}, 3'b010);
        @(posedge clk);
        #1;
        check("n3_out_valid", {63'd0, out_valid3}, 1);
        check("n3_out_data", out_data3, in_data3[W +: W]);
        check("n3_out_ch", {62'd0, out_ch3}, 1);
        sel3 = 2'd3;
        #1;
        check("n3_in_ready_sel3", {61'd0, in_ready3}, 0);
        @(posedge clk);
        #1;
        check("n3_out_valid_drain", {63'd0, out_valid3}, 0);
        @(posedge clk);
        #1;
        check("n3_out_valid_idle", {63'd0, out_valid3}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
